// File: rtl/overlay_pkg.sv
// overlay_pkg
// Shared types and constants for the VGA overlay compositor.
//   fade_state_t : overlay visibility state machine encoding
//   ALPHA_MAX    : full overlay weight (alpha range 0..ALPHA_MAX)
//   DEFAULT_KEY_COLOR : overlay value treated as transparent
//   chan_t       : one 2-bit colour channel
package overlay_pkg;

    typedef enum logic [1:0] {
        ST_HIDDEN   = 2'd0,
        ST_FADE_IN  = 2'd1,
        ST_SHOWN    = 2'd2,
        ST_FADE_OUT = 2'd3
    } fade_state_t;

    localparam logic [2:0] ALPHA_MAX         = 3'd4;
    localparam logic [5:0] DEFAULT_KEY_COLOR = 6'b100001;

    typedef logic [1:0] chan_t;

endpackage

// File: rtl/overlay_mixer_blend.sv
// channel_blend
// Combinational blend of one 2-bit colour channel:
//   mix = (ov*alpha + bg*(ALPHA_MAX-alpha)) >> 2, truncating.
// Ports:
//   ov    in  2  overlay channel
//   bg    in  2  background channel
//   alpha in  3  overlay weight, 0..ALPHA_MAX
//   mix   out 2  blended channel
module channel_blend
    import overlay_pkg::*;
(
    input  chan_t      ov,
    input  chan_t      bg,
    input  logic [2:0] alpha,
    output chan_t      mix
);

    // Largest term is 3*4 = 12, so 5 bits hold the weighted sum with room.
    logic [4:0] sum;

    assign sum = 5'(ov) * 5'(alpha) + 5'(bg) * 5'(ALPHA_MAX - alpha);
    assign mix = chan_t'(sum >> 2);

endmodule

// File: rtl/overlay_mixer.sv
// overlay_mixer
// Composites a transparency-keyed 6-bit overlay (RRGGBB) over the background
// colour for the VGA PMOD, with a frame-synchronous show/hide fade.
// Two-stage pipeline: stage 1 registers the timing-generator signals and
// both colours; stage 2 registers the blended colour and the syncs, so
// everything presented on cycle N leaves on cycle N+2.
//
// Build option: define OVERLAY_FADE_EN to step alpha 0..4 over
// FADE_FRAMES frames per step. Without it, a toggle flips alpha directly
// between 0 and 4 at the next frame tick and FADE_FRAMES is not used.
//
// Ports:
//   clk             in  1  pixel clock
//   rst_n           in  1  asynchronous active-low reset
//   hsync_in        in  1  hsync from timing generator (active-low)
//   vsync_in        in  1  vsync from timing generator (active-low)
//   active_in       in  1  visible-area flag
//   bg_rgb          in  6  background colour
//   ov_rgb          in  6  overlay colour, KEY_COLOR = transparent
//   toggle          in  1  single-cycle show/hide request
//   hsync_out       out 1  hsync delayed two cycles
//   vsync_out       out 1  vsync delayed two cycles
//   rgb_out         out 6  composited colour
//   alpha           out 3  current overlay weight, 0..4
//   overlay_visible out 1  alpha != 0
//
// Handshake: toggle is a fire-and-forget pulse with no ready. One request
// is held until the next frame tick; extra pulses before that tick merge
// into it, and a pulse on the tick cycle itself is taken at that tick.
module overlay_mixer
    import overlay_pkg::*;
#(
    parameter int unsigned FADE_FRAMES = 8,
    parameter logic [5:0]  KEY_COLOR   = DEFAULT_KEY_COLOR
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic       active_in,
    input  logic [5:0] bg_rgb,
    input  logic [5:0] ov_rgb,
    input  logic       toggle,
    output logic       hsync_out,
    output logic       vsync_out,
    output logic [5:0] rgb_out,
    output logic [2:0] alpha,
    output logic       overlay_visible
);

    if (FADE_FRAMES < 2 || FADE_FRAMES > 255) begin : g_fade_frames_range
        $error("overlay_mixer: FADE_FRAMES must be within 2..255");
    end

    // ------------------------------------------------------------------
    // Stage 1: input registers and frame tick
    // ------------------------------------------------------------------
    logic       s1_hsync;
    logic       s1_vsync;
    logic       s1_active;
    logic [5:0] s1_bg;
    logic [5:0] s1_ov;
    logic       vsync_prev;
    logic       frame_tick;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_hsync   <= 1'b1;
            s1_vsync   <= 1'b1;
            s1_active  <= 1'b0;
            s1_bg      <= '0;
            s1_ov      <= '0;
            vsync_prev <= 1'b1;
        end else begin
            s1_hsync   <= hsync_in;
            s1_vsync   <= vsync_in;
            s1_active  <= active_in;
            s1_bg      <= bg_rgb;
            s1_ov      <= ov_rgb;
            vsync_prev <= s1_vsync;
        end
    end

    // Falling edge of the registered vsync: the start of vertical sync,
    // well away from any visible pixel.
    assign frame_tick = vsync_prev & ~s1_vsync;

    // ------------------------------------------------------------------
    // Visibility state machine
    // ------------------------------------------------------------------
    fade_state_t state_q, state_d;
    logic [2:0]  alpha_q, alpha_d;
    logic        pending_q, pending_d;
    logic        request;

    // A toggle on the tick cycle counts as already pending.
    assign request = pending_q | toggle;

`ifdef OVERLAY_FADE_EN
    localparam logic [7:0] FCNT_LAST = 8'(FADE_FRAMES - 1);

    logic [7:0] fcnt_q, fcnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_HIDDEN;
            alpha_q   <= '0;
            pending_q <= 1'b0;
            fcnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            alpha_q   <= alpha_d;
            pending_q <= pending_d;
            fcnt_q    <= fcnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        alpha_d   = alpha_q;
        pending_d = request;
        fcnt_d    = fcnt_q;
        if (frame_tick) begin
            pending_d = 1'b0;
            if (request) begin
                // Reverse direction but keep the current weight.
                fcnt_d = '0;
                unique case (state_q)
                    ST_HIDDEN, ST_FADE_OUT: state_d = ST_FADE_IN;
                    ST_SHOWN,  ST_FADE_IN:  state_d = ST_FADE_OUT;
                endcase
            end else if (state_q == ST_FADE_IN || state_q == ST_FADE_OUT) begin
                if (fcnt_q == FCNT_LAST) begin
                    fcnt_d = '0;
                    if (state_q == ST_FADE_IN) begin
                        // Saturate at full weight; a fade reversed at the
                        // top can reach here already at ALPHA_MAX.
                        if (alpha_q >= ALPHA_MAX - 3'd1) begin
                            alpha_d = ALPHA_MAX;
                            state_d = ST_SHOWN;
                        end else begin
                            alpha_d = alpha_q + 3'd1;
                        end
                    end else begin
                        if (alpha_q <= 3'd1) begin
                            alpha_d = '0;
                            state_d = ST_HIDDEN;
                        end else begin
                            alpha_d = alpha_q - 3'd1;
                        end
                    end
                end else begin
                    fcnt_d = fcnt_q + 8'd1;
                end
            end
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_HIDDEN;
            alpha_q   <= '0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            alpha_q   <= alpha_d;
            pending_q <= pending_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        alpha_d   = alpha_q;
        pending_d = request;
        if (frame_tick) begin
            pending_d = 1'b0;
            if (request) begin
                if (state_q == ST_SHOWN) begin
                    state_d = ST_HIDDEN;
                    alpha_d = '0;
                end else begin
                    state_d = ST_SHOWN;
                    alpha_d = ALPHA_MAX;
                end
            end
        end
    end
`endif

    assign alpha           = alpha_q;
    assign overlay_visible = (alpha_q != 3'd0);

    // ------------------------------------------------------------------
    // Stage 2: blend and output registers
    // ------------------------------------------------------------------
    chan_t      mix_r, mix_g, mix_b;
    logic [5:0] rgb_next;

    channel_blend u_blend_r (
        .ov    (s1_ov[5:4]),
        .bg    (s1_bg[5:4]),
        .alpha (alpha_q),
        .mix   (mix_r)
    );

    channel_blend u_blend_g (
        .ov    (s1_ov[3:2]),
        .bg    (s1_bg[3:2]),
        .alpha (alpha_q),
        .mix   (mix_g)
    );

    channel_blend u_blend_b (
        .ov    (s1_ov[1:0]),
        .bg    (s1_bg[1:0]),
        .alpha (alpha_q),
        .mix   (mix_b)
    );

    always_comb begin
        rgb_next = '0;
        if (s1_active) begin
            if (s1_ov == KEY_COLOR) begin
                rgb_next = s1_bg;
            end else begin
                rgb_next = {mix_r, mix_g, mix_b};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync_out <= 1'b1;
            vsync_out <= 1'b1;
            rgb_out   <= '0;
        end else begin
            hsync_out <= s1_hsync;
            vsync_out <= s1_vsync;
            rgb_out   <= rgb_next;
        end
    end

endmodule

// File: doc/overlay_mixer.md
# overlay_mixer

Downstream compositor for the VGA overlay path. Takes the combinational 6-bit overlay colour (RRGGBB, transparency-keyed) and the background colour, both produced for the same timing-generator pixel, and alpha-blends them under a frame-synchronous fade state machine. It drives the registered RGB and sync outputs to the VGA PMOD, with sync delayed to match pixel latency.

## Interface
- `FADE_FRAMES`, 8: frames per alpha step (2..255).
- `KEY_COLOR`, 6'b100001: overlay value meaning "transparent".
- `clk`  in  1  pixel clock.
- `rst_n`  in  1  reset; one clock, asynchronous, active-low.
- `hsync_in`  in  1  timing-generator hsync (active-low).
- `vsync_in`  in  1  timing-generator vsync (active-low).
- `active_in`  in  1  visible-area flag.
- `bg_rgb`  in  6  background colour.
- `ov_rgb`  in  6  overlay colour; `KEY_COLOR` = transparent.
- `toggle`  in  1  single-cycle request to show/hide overlay.
- `hsync_out`  out  1  delayed hsync.
- `vsync_out`  out  1  delayed vsync.
- `rgb_out`  out  6  composited colour.
- `alpha`  out  3  current overlay weight, 0..4.
- `overlay_visible`  out  1  high when `alpha` != 0.

## Operation
- States: HIDDEN (alpha 0), FADE_IN, SHOWN (alpha 4), FADE_OUT.
- Frame tick: one-cycle pulse when registered `vsync_in` goes 1->0.
- `toggle` sets `pending`; further toggles while pending are ignored. `pending` is consumed only on a frame tick; toggle coincident with tick is applied at that tick.
- On tick with pending: HIDDEN->FADE_IN, SHOWN->FADE_OUT, FADE_IN->FADE_OUT, FADE_OUT->FADE_IN; alpha is kept and `fcnt` cleared to 0. A pending transition replaces, not adds to, the step logic on that tick.
- On tick without pending in FADE_IN/FADE_OUT: `fcnt` increments; at `fcnt == FADE_FRAMES-1`, `fcnt` <= 0 and alpha +1 (FADE_IN) or -1 (FADE_OUT). Alpha reaching 4 enters SHOWN; reaching 0 enters HIDDEN. Alpha never leaves 0..4.
- Blend per 2-bit channel: out = (ov*alpha + bg*(4-alpha)) >> 2, 5-bit intermediate, truncating. Alpha 4 gives ov exactly; alpha 0 gives bg exactly.
- If `ov_rgb == KEY_COLOR`, output = `bg_rgb` regardless of alpha.
- If `active_in` is low, `rgb_out` = 0.

## Timing
- Two-stage pipeline. Stage 1 registers hsync/vsync/active/bg/ov. Stage 2 registers blend result and syncs.
- Input on cycle N appears on outputs at N+2. Sync and RGB stay aligned.
- Alpha and state change only on frame ticks. Alpha is sampled by stage 2, so a change lands during vsync and never mid-visible-frame.
- Reset values: `hsync_out` = 1, `vsync_out` = 1, `rgb_out` = 0, `alpha` = 0, `overlay_visible` = 0; state HIDDEN, `fcnt` 0, `pending` 0, pipeline regs = syncs 1, others 0.
- Reset mid-fade returns to HIDDEN immediately (asynchronous); no resume.

## Configuration
- `OVERLAY_FADE_EN` defined: behaviour as above.
- Undefined: FADE_IN/FADE_OUT and `fcnt` are removed. A pending toggle at frame tick flips HIDDEN (alpha 0) <-> SHOWN (alpha 4) directly. `FADE_FRAMES` is unused.

## Structure
- `overlay_pkg`: state enum, `ALPHA_MAX` = 4, default `KEY_COLOR`, 2-bit channel type.
- Sub-module `channel_blend` (combinational 2-bit blend, inputs ov/bg/alpha). Instantiated three times in stage 2.

## Test plan
- Reset, then run one frame with no toggle, `bg_rgb` = 6'b010101 and active: `rgb_out` = 010101 two cycles after each input; syncs delayed exactly 2 cycles.
- With `FADE_FRAMES` = 2, toggle once, `ov_rgb` = 111111, `bg_rgb` = 000000: alpha steps 0,1,2,3,4 every 2 frames. Channel values 0,0,1,2,3, i.e. `rgb_out` 000000, 000000, 010101, 101010, 111111. Ends in SHOWN.
- In SHOWN with `ov_rgb` = 100001 and `bg_rgb` = 001100: `rgb_out` = 001100.
- Toggle in FADE_IN at alpha 2: at next tick, FADE_OUT with alpha 2. After 2x`FADE_FRAMES` frames, alpha 0 and HIDDEN.
- Two toggles inside one frame plus toggle coincident with tick: exactly one transition. Pixels with `active_in` low output 000000 at alpha 4.
- Assert `rst_n` low mid-fade: all outputs take reset values that cycle. Build without `OVERLAY_FADE_EN`: toggle gives alpha 0->4 at the first tick.
